se_sram_srw_param_be: RTL and testbench

//  Parametrised synchronous single-port SRAM, successor to the fixed 64Kx8 srw part.

---
 rtl/se_sram_pkg.sv | 13 +
 rtl/se_sram_clear_ctrl.sv | 34 +++
 rtl/se_sram_srw_param_be.sv | 79 +++++++
 tb/tb_se_sram_srw_param_be.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/se_sram_pkg.sv
// se_sram_pkg: shared state encoding and parameter helpers for the parametrised srw SRAM
package se_sram_pkg;
  typedef enum logic {
    SRAM_STATE_CLEAR = 1'b0,
    SRAM_STATE_IDLE  = 1'b1
  } sram_state_e;
  function automatic int lanes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction
  function automatic bit params_ok(input int addr_width, input int depth, input int data_width, input int byte_width);
    return (byte_width > 0) && (data_width % byte_width == 0) && (depth > 0) && (depth <= 2 ** addr_width);
  endfunction
endpackage

// File: rtl/se_sram_clear_ctrl.sv
// se_sram_clear_ctrl: post-reset clear sequencer producing clear address/strobe and busy
module se_sram_clear_ctrl
  import se_sram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DEPTH          = 2 ** ADDR_WIDTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  sram_clock,
  input  logic                  reset,
  output logic                  busy,
  output logic                  clear_we,
  output logic [ADDR_WIDTH-1:0] clear_addr
);
  sram_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] clear_addr_q, clear_addr_d;
  always_comb begin
    clear_we     = (state_q == SRAM_STATE_CLEAR) && !reset;
    state_d      = (clear_we && clear_addr_q == ADDR_WIDTH'(DEPTH - 1)) ? SRAM_STATE_IDLE : state_q;
    clear_addr_d = clear_we ? clear_addr_q + ADDR_WIDTH'(1) : clear_addr_q;
    busy         = reset ? CLEAR_ON_RESET : (state_q == SRAM_STATE_CLEAR);
  end
  always_ff @(posedge sram_clock) begin
    if (reset) begin
      if (CLEAR_ON_RESET) state_q <= SRAM_STATE_CLEAR;
      else state_q <= SRAM_STATE_IDLE;
      clear_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
    end
  end
  assign clear_addr = clear_addr_q;
endmodule

// File: rtl/se_sram_srw_param_be.sv
// se_sram_srw_param_be: parametrised single-port SRAM with byte lanes, optional output register and post-reset clear
module se_sram_srw_param_be
  import se_sram_pkg::*;
#(
  parameter int  ADDR_WIDTH     = 16,
  parameter int  DEPTH          = 2 ** ADDR_WIDTH,
  parameter int  DATA_WIDTH     = 8,
  parameter int  BYTE_WIDTH     = 8,
  parameter bit  OUTPUT_REG     = 1'b0,
  parameter bit  CLEAR_ON_RESET = 1'b1,
  localparam int LANES          = lanes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  sram_clock,
  input  logic                  reset,
  input  logic                  select,
  input  logic                  read_not_write,
  input  logic [LANES-1:0]      write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  clear_we, in_range, rd, wr, src_valid;
  logic [ADDR_WIDTH-1:0] clear_addr, wr_addr;
  logic [LANES-1:0]      lane_we;
  logic [DATA_WIDTH-1:0] wr_data, rd_word, src_data;
  logic [DATA_WIDTH-1:0] pipe_data_q, pipe_data_d, data_out_q, data_out_d;
  logic                  pipe_valid_q, pipe_valid_d, data_valid_q, data_valid_d;
  if (!params_ok(ADDR_WIDTH, DEPTH, DATA_WIDTH, BYTE_WIDTH)) begin : g_bad_params
    $error("se_sram_srw_param_be: DATA_WIDTH must be a multiple of BYTE_WIDTH and DEPTH <= 2**ADDR_WIDTH");
  end
  se_sram_clear_ctrl #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DEPTH         (DEPTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_ctrl (
    .sram_clock(sram_clock),
    .reset     (reset),
    .busy      (busy),
    .clear_we  (clear_we),
    .clear_addr(clear_addr)
  );
  always_comb begin
    in_range     = {1'b0, address} < (ADDR_WIDTH + 1)'(DEPTH);
    rd           = select && read_not_write && !busy && !reset;
    wr           = select && !read_not_write && !busy && !reset && in_range;
    lane_we      = clear_we ? '1 : (wr ? write_enable : '0);
    wr_addr      = clear_we ? clear_addr : address;
    wr_data      = clear_we ? '0 : write_data;
    rd_word      = in_range ? mem[address] : '0;
    pipe_valid_d = rd;
    pipe_data_d  = rd ? rd_word : pipe_data_q;
    src_valid    = OUTPUT_REG ? pipe_valid_q : rd;
    src_data     = OUTPUT_REG ? pipe_data_q : rd_word;
    data_valid_d = src_valid;
    data_out_d   = src_valid ? src_data : data_out_q;
  end
  always_ff @(posedge sram_clock) begin
    for (int i = 0; i < LANES; i++)
      if (lane_we[i]) mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
  end
  always_ff @(posedge sram_clock) begin
    if (reset) begin
      pipe_valid_q <= 1'b0;
      pipe_data_q  <= '0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_data_q  <= pipe_data_d;
      data_valid_q <= data_valid_d;
      data_out_q   <= data_out_d;
    end
  end
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
endmodule

// File: tb/tb_se_sram_srw_param_be.sv
// tb_se_sram_srw_param_be: three SRAM configurations driven in lockstep and checked every cycle against a word-array reference model
module tb_se_sram_srw_param_be;
  localparam int DEP  [3] = '{16, 16, 12};
  localparam bit OREG [3] = '{1'b0, 1'b1, 1'b0};
  localparam bit CLR  [3] = '{1'b1, 1'b1, 1'b0};
  logic        clk = 1'b0;
  logic        reset = 1'b1, select = 1'b0, rnw = 1'b0;
  logic [3:0]  we = '0, addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] dout [3];
  logic        vld  [3];
  logic        bsy  [3];
  int          vectors = 0, miscompares = 0;
  logic [31:0] m  [3][16];
  int          clr_left [3];
  bit          pv [3], ev [3];
  logic [31:0] pd [3], ed [3];
  always #5 clk = ~clk;
  se_sram_srw_param_be #(.ADDR_WIDTH(4), .DEPTH(16), .DATA_WIDTH(32), .BYTE_WIDTH(8), .OUTPUT_REG(1'b0), .CLEAR_ON_RESET(1'b1)) u_a (
    .sram_clock(clk), .reset(reset), .select(select), .read_not_write(rnw), .write_enable(we),
    .address(addr), .write_data(wdata), .data_out(dout[0]), .data_valid(vld[0]), .busy(bsy[0]));
  se_sram_srw_param_be #(.ADDR_WIDTH(4), .DEPTH(16), .DATA_WIDTH(32), .BYTE_WIDTH(8), .OUTPUT_REG(1'b1), .CLEAR_ON_RESET(1'b1)) u_b (
    .sram_clock(clk), .reset(reset), .select(select), .read_not_write(rnw), .write_enable(we),
    .address(addr), .write_data(wdata), .data_out(dout[1]), .data_valid(vld[1]), .busy(bsy[1]));
  se_sram_srw_param_be #(.ADDR_WIDTH(4), .DEPTH(12), .DATA_WIDTH(32), .BYTE_WIDTH(8), .OUTPUT_REG(1'b0), .CLEAR_ON_RESET(1'b0)) u_c (
    .sram_clock(clk), .reset(reset), .select(select), .read_not_write(rnw), .write_enable(we),
    .address(addr), .write_data(wdata), .data_out(dout[2]), .data_valid(vld[2]), .busy(bsy[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin : per_inst
      bit          rv, ov;
      logic [31:0] rdat, od;
      rv = 1'b0;
      rdat = '0;
      ov = 1'b0;
      od = '0;
      if (reset) begin
        clr_left[k] = CLR[k] ? DEP[k] : 0;
        if (CLR[k]) for (int a = 0; a < 16; a++) m[k][a] = '0;
        pv[k] = 1'b0;
        pd[k] = '0;
        ev[k] = 1'b0;
        ed[k] = '0;
      end else begin
        if (clr_left[k] > 0) clr_left[k]--;
        else if (select && rnw) begin
          rv = 1'b1;
          rdat = (int'(addr) < DEP[k]) ? m[k][addr] : '0;
        end else if (select && int'(addr) < DEP[k])
          for (int l = 0; l < 4; l++) if (we[l]) m[k][addr][8*l +: 8] = wdata[8*l +: 8];
        if (OREG[k]) begin
          ov = pv[k];
          od = pd[k];
          pv[k] = rv;
          pd[k] = rdat;
        end else begin
          ov = rv;
          od = rdat;
        end
        ev[k] = ov;
        if (ov) ed[k] = od;
      end
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("busy[%0d]", k), 32'(bsy[k]), reset ? 32'(CLR[k]) : 32'(clr_left[k] > 0));
      chk($sformatf("data_valid[%0d]", k), 32'(vld[k]), 32'(ev[k]));
      chk($sformatf("data_out[%0d]", k), dout[k], ed[k]);
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask
  task automatic acc(input bit s, input bit r, input logic [3:0] w, input logic [3:0] a, input logic [31:0] d);
    select = s;
    rnw = r;
    we = w;
    addr = a;
    wdata = d;
    step();
  endtask
  task automatic rand_acc();
    acc(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), $urandom);
  endtask
  initial begin
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) acc(1'b1, 1'b0, 4'hF, 4'(i), $urandom);
    for (int i = 0; i < 16; i++) acc(1'b1, 1'b1, 4'h0, 4'(i), '0);
    repeat (2) acc(1'b0, 1'b0, 4'h0, 4'h0, '0);
    acc(1'b1, 1'b0, 4'hF, 4'd5, 32'hAABBCCDD);
    acc(1'b1, 1'b0, 4'b0101, 4'd5, 32'h11223344);
    acc(1'b1, 1'b1, 4'h0, 4'd5, '0);
    repeat (2) acc(1'b0, 1'b0, 4'h0, 4'h0, '0);
    for (int k = 0; k < 3; k++) chk($sformatf("lane_merge[%0d]", k), dout[k], 32'hAA22CC44);
    for (int i = 1; i <= 3; i++) acc(1'b1, 1'b1, 4'h0, 4'(i), '0);
    repeat (3) acc(1'b0, 1'b1, 4'hF, 4'h0, '1);
    acc(1'b1, 1'b1, 4'hF, 4'd5, 32'h000000FF);
    repeat (2) acc(1'b0, 1'b0, 4'h0, 4'h0, '0);
    for (int k = 0; k < 3; k++) chk($sformatf("read_no_write[%0d]", k), dout[k], 32'hAA22CC44);
    acc(1'b1, 1'b0, 4'hF, 4'd6, 32'h5A5AC3C3);
    acc(1'b1, 1'b1, 4'h0, 4'd6, '0);
    repeat (2) acc(1'b0, 1'b0, 4'h0, 4'h0, '0);
    for (int k = 0; k < 3; k++) chk($sformatf("raw[%0d]", k), dout[k], 32'h5A5AC3C3);
    acc(1'b1, 1'b0, 4'hF, 4'd13, 32'hDEADBEEF);
    acc(1'b1, 1'b1, 4'h0, 4'd13, '0);
    repeat (2) acc(1'b0, 1'b0, 4'h0, 4'h0, '0);
    chk("oob_in_range_a", dout[0], 32'hDEADBEEF);
    chk("oob_read_c", dout[2], 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (7) rand_acc();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (16) rand_acc();
    for (int i = 0; i < 16; i++) acc(1'b1, 1'b1, 4'h0, 4'(i), '0);
    repeat (2) acc(1'b0, 1'b0, 4'h0, 4'h0, '0);
    repeat (400) begin
      reset = ($urandom_range(47) == 0);
      rand_acc();
    end
    reset = 1'b0;
    repeat (20) rand_acc();
    repeat (2) acc(1'b0, 1'b0, 4'h0, 4'h0, '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
